ws2812_frame_sched: RTL and testbench



---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_pattern_gen.sv | 33 +++
 rtl/ws2812_frame_sched.sv | 164 ++++++++++++++++
 tb/tb_ws2812_frame_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ============================================================================
// ws2812_pkg : shared pattern indices, scheduler states and word width
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ws2812_pkg;

  localparam int GRB_W = 24;

  localparam logic [2:0] PAT_OFF   = 3'd0;
  localparam logic [2:0] PAT_SOLID = 3'd1;
  localparam logic [2:0] PAT_BLINK = 3'd2;
  localparam logic [2:0] PAT_CHASE = 3'd3;
  localparam logic [2:0] PAT_ALT   = 3'd4;
  localparam logic [2:0] PAT_NUM   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_LATCH = 3'd4
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/ws2812_pattern_gen.sv
// ============================================================================
// ws2812_pattern_gen : combinational GRB word for one pixel of a pattern
// Revision           : 1.0
// ============================================================================
`default_nettype none

module ws2812_pattern_gen
  import ws2812_pkg::*;
#(
  parameter int               IDX_W    = 3,
  parameter logic [GRB_W-1:0] COLOR_ON = 24'h001000
) (
  input  logic [2:0]       i_pat,
  input  logic [IDX_W-1:0] i_index,
  input  logic [IDX_W-1:0] i_chase,
  input  logic             i_blink_phase,
  output logic [GRB_W-1:0] o_word
);

  always_comb begin
    o_word = '0;
    case (i_pat)
      PAT_SOLID: o_word = COLOR_ON;
      PAT_BLINK: if (i_blink_phase) o_word = COLOR_ON;
      PAT_CHASE: if (i_index == i_chase) o_word = COLOR_ON;
      PAT_ALT:   if (i_index[0] == i_blink_phase) o_word = COLOR_ON;
      default:   o_word = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ws2812_frame_sched.sv
// ============================================================================
// ws2812_frame_sched : frame timer, pixel streaming and latch gap for WS2812
// Revision           : 1.0
// ============================================================================
`default_nettype none

module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int               NUM_LEDS     = 8,
  parameter int               FRAME_CYCLES = 1000000,
  parameter int               LATCH_CYCLES = 15000,
  parameter int               BLINK_FRAMES = 25,
  parameter logic [GRB_W-1:0] COLOR_ON     = 24'h001000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       i_pattern_select,
  output logic [GRB_W-1:0] o_pix_data,
  output logic             o_pix_valid,
  input  logic             i_pix_ready,
  input  logic             i_tx_idle,
  output logic             o_frame_busy,
  output logic             o_frame_done
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam int FT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int LT_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [FT_W-1:0]  c_frame_last = FT_W'(FRAME_CYCLES - 1);
  localparam logic [LT_W-1:0]  c_latch_last = LT_W'(LATCH_CYCLES - 1);
  localparam logic [BC_W-1:0]  c_blink_last = BC_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_LEDS - 1);

  sched_state_t     r_state;
  logic [FT_W-1:0]  r_frame_cnt;
  logic             r_tick_pend;
  logic [2:0]       r_pat_q;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] r_chase;
  logic [BC_W-1:0]  r_blink_cnt;
  logic             r_blink_phase;
  logic [LT_W-1:0]  r_latch_cnt;
  logic [GRB_W-1:0] r_pix_data;
  logic             r_pix_valid;
  logic             r_frame_busy;
  logic             r_frame_done;

  logic             w_frame_tick;
  logic [2:0]       w_pat_in;
  logic [2:0]       w_gen_pat;
  logic [IDX_W-1:0] w_gen_idx;
  logic [GRB_W-1:0] w_gen_word;

  assign w_frame_tick = (r_frame_cnt == c_frame_last);
  assign w_pat_in     = (i_pattern_select >= PAT_NUM) ? PAT_OFF : i_pattern_select;

  // The generator always looks one word ahead so pix_data can be registered without bubbles.
  assign w_gen_pat = (r_state == ST_LOAD) ? w_pat_in : r_pat_q;
  assign w_gen_idx = (r_state == ST_LOAD) ? '0 : r_index + 1'b1;

  ws2812_pattern_gen #(
    .IDX_W    (IDX_W),
    .COLOR_ON (COLOR_ON)
  ) u_pattern_gen (
    .i_pat         (w_gen_pat),
    .i_index       (w_gen_idx),
    .i_chase       (r_chase),
    .i_blink_phase (r_blink_phase),
    .o_word        (w_gen_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tick_pend   <= 1'b0;
      r_pat_q       <= PAT_OFF;
      r_index       <= '0;
      r_chase       <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_latch_cnt   <= '0;
      r_pix_data    <= '0;
      r_pix_valid   <= 1'b0;
      r_frame_busy  <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      if (w_frame_tick) r_tick_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_frame_tick || r_tick_pend) begin
            r_tick_pend  <= 1'b0;
            r_frame_busy <= 1'b1;
            r_state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_pat_q     <= w_pat_in;
          r_index     <= '0;
          r_pix_data  <= w_gen_word;
          r_pix_valid <= 1'b1;
          r_state     <= ST_SEND;
        end
        ST_SEND: begin
          if (r_pix_valid && i_pix_ready) begin
            if (r_index == c_idx_last) begin
              r_pix_valid <= 1'b0;
              r_state     <= ST_DRAIN;
            end else begin
              r_index    <= r_index + 1'b1;
              r_pix_data <= w_gen_word;
            end
          end
        end
        ST_DRAIN: begin
          if (i_tx_idle) begin
            r_latch_cnt  <= '0;
            r_frame_done <= (LATCH_CYCLES == 1);
            r_state      <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          // frame_done is raised ahead so it coincides with the final latch cycle.
          if (r_latch_cnt == c_latch_last) begin
            r_frame_done <= 1'b0;
            r_frame_busy <= 1'b0;
            r_state      <= ST_IDLE;
            r_chase      <= (r_chase == c_idx_last) ? '0 : r_chase + 1'b1;
            if (r_blink_cnt == c_blink_last) begin
              r_blink_cnt   <= '0;
              r_blink_phase <= ~r_blink_phase;
            end else begin
              r_blink_cnt <= r_blink_cnt + 1'b1;
            end
          end else begin
            r_latch_cnt  <= r_latch_cnt + 1'b1;
            r_frame_done <= (r_latch_cnt + 1'b1 == c_latch_last);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pix_data   = r_pix_data;
  assign o_pix_valid  = r_pix_valid;
  assign o_frame_busy = r_frame_busy;
  assign o_frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_frame_sched.sv
// ============================================================================
// tb_ws2812_frame_sched : self-checking bench for the WS2812 frame scheduler
// Revision              : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ws2812_frame_sched;

  localparam int          N  = 4;
  localparam int          FC = 200;
  localparam int          LC = 20;
  localparam int          BF = 2;
  localparam logic [23:0] ON = 24'h001000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  pattern_select = 3'd0;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        tx_idle = 1'b1;
  logic        frame_busy;
  logic        frame_done;

  always #5 clk = ~clk;

  ws2812_frame_sched #(
    .NUM_LEDS     (N),
    .FRAME_CYCLES (FC),
    .LATCH_CYCLES (LC),
    .BLINK_FRAMES (BF),
    .COLOR_ON     (ON)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_pattern_select (pattern_select),
    .o_pix_data       (pix_data),
    .o_pix_valid      (pix_valid),
    .i_pix_ready      (pix_ready),
    .i_tx_idle        (tx_idle),
    .o_frame_busy     (frame_busy),
    .o_frame_done     (frame_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Serializer stand-in: line goes idle ser_hold cycles after the last accepted word.
  int ser_hold = 10;
  int ser_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_cnt <= 0;
      tx_idle <= 1'b1;
    end else if (pix_valid && pix_ready) begin
      ser_cnt <= ser_hold;
      tx_idle <= 1'b0;
    end else if (ser_cnt > 0) begin
      ser_cnt <= ser_cnt - 1;
      tx_idle <= (ser_cnt == 1);
    end
  end

  int rdy_mode = 0;
  initial begin : ready_drv
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) pix_ready = 1'b1;
      else begin
        pix_ready = (k % 3 == 0);
        k++;
      end
    end
  end

  // Reference model: a frame is a queue of words built from the pattern rules at load time.
  int          m_t = 0, cyc = 0, m_latch = 0, m_chase = 0, m_bcnt = 0, m_p = 0;
  bit          m_pend = 0, m_in = 0, m_load = 0, m_drain = 0, m_phase = 0, m_tick = 0;
  logic [23:0] m_q[$];
  logic        e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [23:0] e_data = 24'h0;

  function automatic logic [23:0] rule_word(input int pat, input int i, input int chase, input bit ph);
    case (pat)
      1:       return ON;
      2:       return ph ? ON : 24'h0;
      3:       return (i == chase) ? ON : 24'h0;
      4:       return ((i % 2) == int'(ph)) ? ON : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; cyc = 0; m_pend = 0; m_in = 0; m_load = 0; m_drain = 0;
      m_latch = 0; m_chase = 0; m_bcnt = 0; m_phase = 0;
      m_q.delete();
      e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_data = 24'h0;
    end else begin
      m_tick = (m_t == FC - 1);
      m_t = (m_t + 1) % FC;
      cyc++;
      if (!m_in) begin
        if (m_tick || m_pend) begin
          m_in = 1; m_load = 1; m_pend = 0;
        end
      end else begin
        if (m_tick) m_pend = 1;
        if (m_load) begin
          m_load = 0;
          m_p = (pattern_select > 3'd4) ? 0 : int'(pattern_select);
          for (int i = 0; i < N; i++) m_q.push_back(rule_word(m_p, i, m_chase, m_phase));
        end else if (m_q.size() > 0) begin
          if (pix_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_drain = 1;
          end
        end else if (m_drain) begin
          if (tx_idle) begin
            m_drain = 0;
            m_latch = LC;
          end
        end else if (m_latch > 0) begin
          m_latch--;
          if (m_latch == 0) begin
            m_in = 0;
            m_chase = (m_chase + 1) % N;
            m_bcnt++;
            if (m_bcnt == BF) begin
              m_bcnt = 0;
              m_phase = !m_phase;
            end
          end
        end
      end
      e_busy  = m_in;
      e_valid = (m_q.size() > 0);
      e_data  = e_valid ? m_q[0] : 24'h0;
      e_done  = m_in && (m_latch == 1);
    end
  end

  // Per-cycle compare plus per-frame event log for the literal checks.
  int   busy_rise[$], first_valid[$], vcnt[$], hs_n[$], holds[$], done_at[$], idle_rise[$], masks[$];
  int   f_v = 0, f_hs = 0, f_hold = 0, f_mask = 0;
  bit   f_first = 0;
  logic prev_busy = 1'b0, prev_idle = 1'b1;

  always @(negedge clk) begin
    #1;
    check("busy", frame_busy, e_busy);
    check("valid", pix_valid, e_valid);
    check("done", frame_done, e_done);
    if (e_valid) check("data", pix_data, e_data);
    if (!rst) begin
      if (frame_busy && !prev_busy) begin
        busy_rise.push_back(cyc);
        f_v = 0; f_hs = 0; f_hold = 0; f_mask = 0; f_first = 1;
      end
      if (pix_valid) begin
        if (f_first) begin
          first_valid.push_back(cyc);
          f_first = 0;
        end
        f_v++;
        if (pix_ready) begin
          if (pix_data == ON && f_hs < N) f_mask = f_mask | (1 << f_hs);
          f_hs++;
        end else begin
          f_hold++;
        end
      end
      if (tx_idle && !prev_idle && frame_busy) idle_rise.push_back(cyc);
      if (frame_done) begin
        done_at.push_back(cyc);
        vcnt.push_back(f_v);
        hs_n.push_back(f_hs);
        holds.push_back(f_hold);
        masks.push_back(f_mask);
      end
    end
    prev_busy = frame_busy;
    prev_idle = tx_idle;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", pix_valid, 0);
    check("rst_busy", frame_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_data", pix_data, 0);
    step(3);
    busy_rise.delete(); first_valid.delete(); vcnt.delete(); hs_n.delete();
    holds.delete(); done_at.delete(); idle_rise.delete(); masks.delete();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    step(2);

    // Solid pattern, always ready
    pattern_select = 3'd1;
    do_reset();
    step(460);
    check("t1_first_tick", qi(busy_rise, 0), 200);
    check("t1_first_valid", qi(first_valid, 0), 201);
    check("t1_valid_cycles", qi(vcnt, 0), 4);
    check("t1_mask", qi(masks, 0), 4'b1111);
    check("t1_latch_gap", qi(done_at, 0) - qi(idle_rise, 0), 20);
    check("t1_second_tick", qi(busy_rise, 1), 400);

    // Backpressure 1,0,0
    rdy_mode = 1;
    step(200);
    check("t2_handshakes", qi(hs_n, 2), 4);
    check("t2_held", qi(holds, 2) > 0, 1);
    check("t2_mask", qi(masks, 2), 4'b1111);
    rdy_mode = 0;

    // Chase over five frames
    pattern_select = 3'd3;
    do_reset();
    step(1060);
    check("t3_f0", qi(masks, 0), 4'b0001);
    check("t3_f1", qi(masks, 1), 4'b0010);
    check("t3_f2", qi(masks, 2), 4'b0100);
    check("t3_f3", qi(masks, 3), 4'b1000);
    check("t3_f4", qi(masks, 4), 4'b0001);

    // Blink
    pattern_select = 3'd2;
    do_reset();
    step(860);
    check("t4_blink_f0", qi(masks, 0), 4'b0000);
    check("t4_blink_f1", qi(masks, 1), 4'b0000);
    check("t4_blink_f2", qi(masks, 2), 4'b1111);
    check("t4_blink_f3", qi(masks, 3), 4'b1111);

    // Alternating
    pattern_select = 3'd4;
    do_reset();
    step(860);
    check("t4_alt_f1", qi(masks, 1), 4'b0101);
    check("t4_alt_f3", qi(masks, 3), 4'b1010);

    // Overrun with pattern change mid-frame
    pattern_select = 3'd1;
    ser_hold = 450;
    do_reset();
    step(202);
    pattern_select = 3'd0;
    step(300);
    ser_hold = 10;
    step(350);
    check("t5_first_tick", qi(busy_rise, 0), 200);
    check("t5_latch_gap", qi(done_at, 0) - qi(idle_rise, 0), 20);
    check("t5_pended_start", qi(busy_rise, 1), qi(done_at, 0) + 2);
    check("t5_third_start", qi(busy_rise, 2), 800);
    check("t5_frames", busy_rise.size(), 3);
    check("t5_mask_cur", qi(masks, 0), 4'b1111);
    check("t5_mask_next", qi(masks, 1), 4'b0000);

    // Reset in the middle of the second frame's SEND
    pattern_select = 3'd3;
    do_reset();
    b = 0;
    while (!(busy_rise.size() == 2 && f_hs == 2) && b < 600) begin
      step(1);
      b++;
    end
    check("t6_reached_send", b < 600, 1);
    check("t6_pre_mask", qi(masks, 0), 4'b0001);
    check("t6_valid_before_rst", pix_valid, 1);
    do_reset();
    step(260);
    check("t6_first_tick", qi(busy_rise, 0), 200);
    check("t6_chase_restart", qi(masks, 0), 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
